// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame data width and default baud divisor.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-wide valid/ready handshake feeding the UART transmitter.
interface uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] tx_data;
    logic                      tx_valid;
    logic                      tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags; an extra pointer bit separates full from empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0]  DEPTH_P = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      wr_nxt_s;
    logic [AW:0]      rd_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && !full_r;
    assign do_pop_s  = pop && !empty_r;

    // Next pointer values; flags are derived from these so they are valid the cycle after the edge
    always_comb begin
        wr_nxt_s = wr_ptr_r;
        rd_nxt_s = rd_ptr_r;
        if (do_push_s) begin
            wr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_nxt_s = wr_ptr_r;
        end
        if (do_pop_s) begin
            rd_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_nxt_s = rd_ptr_r;
        end
    end

    // Pointer and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_nxt_s;
            rd_ptr_r <= rd_nxt_s;
            full_r   <= ((wr_nxt_s - rd_nxt_s) == DEPTH_P);
            empty_r  <= (wr_nxt_s == rd_nxt_s);
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r[AW-1:0]];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: handshake into a small FIFO, then start/data/stop framing at a fixed baud divisor.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_tx_if.slave  bus,
    output logic      tx,
    output logic      busy
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  BAUD_ONE  = CNT_W'(1);
    localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t              state_r;
    uart_tx_state_t              state_nxt_s;
    logic [CNT_W-1:0]            baud_cnt_r;
    logic [CNT_W-1:0]            baud_nxt_s;
    logic [2:0]                  bit_idx_r;
    logic [2:0]                  bit_nxt_s;
    logic [UART_DATA_BITS-1:0]   shift_r;
    logic [UART_DATA_BITS-1:0]   shift_nxt_s;
    logic                        tx_r;
    logic                        tx_nxt_s;
    logic                        baud_done_s;
    logic                        pop_s;
    logic                        push_s;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic [UART_DATA_BITS-1:0]   fifo_rdata_s;

    assign baud_done_s  = (baud_cnt_r == BAUD_LAST);
    assign push_s       = bus.tx_valid && !fifo_full_s;
    assign bus.tx_ready = !fifo_full_s;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (bus.tx_data),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; STOP chains straight into START when another byte is waiting
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) state_nxt_s = START;
                else               state_nxt_s = IDLE;
            end
            START: begin
                if (baud_done_s) state_nxt_s = DATA;
                else             state_nxt_s = START;
            end
            DATA: begin
                if (baud_done_s && (bit_idx_r == BIT_LAST)) state_nxt_s = STOP;
                else                                         state_nxt_s = DATA;
            end
            STOP: begin
                if (baud_done_s) begin
                    if (!fifo_empty_s) state_nxt_s = START;
                    else               state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath next values; tx is computed from the next state so the line flop changes with the FSM
    always_comb begin
        pop_s       = 1'b0;
        baud_nxt_s  = '0;
        bit_nxt_s   = bit_idx_r;
        shift_nxt_s = shift_r;
        tx_nxt_s    = 1'b1;
        if (state_r != IDLE) begin
            baud_nxt_s = baud_done_s ? '0 : (baud_cnt_r + BAUD_ONE);
        end else begin
            baud_nxt_s = '0;
        end
        if ((state_r == DATA) && baud_done_s) begin
            shift_nxt_s = {1'b0, shift_r[UART_DATA_BITS-1:1]};
            bit_nxt_s   = bit_idx_r + 3'd1;
        end else begin
            shift_nxt_s = shift_r;
            bit_nxt_s   = bit_idx_r;
        end
        if ((state_nxt_s == START) && (state_r != START)) begin
            pop_s       = 1'b1;
            baud_nxt_s  = '0;
            bit_nxt_s   = 3'd0;
            shift_nxt_s = fifo_rdata_s;
        end else begin
            pop_s       = 1'b0;
        end
        case (state_nxt_s)
            START:   tx_nxt_s = 1'b0;
            DATA:    tx_nxt_s = shift_nxt_s[0];
            default: tx_nxt_s = 1'b1;
        endcase
    end

    // Baud counter, bit index, shift register and line flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_r <= '0;
            bit_idx_r  <= 3'd0;
            shift_r    <= '0;
            tx_r       <= 1'b1;
        end else begin
            baud_cnt_r <= baud_nxt_s;
            bit_idx_r  <= bit_nxt_s;
            shift_r    <= shift_nxt_s;
            tx_r       <= tx_nxt_s;
        end
    end

    assign tx   = tx_r;
    assign busy = (state_r != IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: pushes queue expected bytes, a line monitor decodes frames and compares.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic tx;
    logic busy;

    uart_tx_if bus_if ();

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks    = 0;
    int         n_fail      = 0;
    int         frames_done = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Line monitor: one frame = start, 8 data bits LSB first, stop, each exactly CPB cycles
    bit         mon_active = 1'b0;
    int         mon_cnt;
    bit         mon_bad;
    logic [9:0] mon_frame;
    logic [7:0] mon_rx;
    logic [7:0] mon_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && (tx == 1'b0)) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    mon_bad    = 1'b0;
                    mon_rx     = 8'h00;
                    start_q.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame: start bit at cycle %0d with nothing queued", cyc);
                        mon_exp = 8'h00;
                    end else begin
                        mon_exp = exp_q.pop_front();
                    end
                    mon_frame = {1'b1, mon_exp, 1'b0};
                end
                if (mon_active) begin
                    if (tx !== mon_frame[mon_cnt / CPB]) mon_bad = 1'b1;
                    if ((mon_cnt % CPB == CPB / 2) && (mon_cnt / CPB >= 1) && (mon_cnt / CPB <= 8))
                        mon_rx[mon_cnt / CPB - 1] = tx;
                    if (mon_cnt == FRAME - 1) begin
                        chk("frame_byte", mon_rx, mon_exp);
                        chk("frame_shape", mon_bad, 0);
                        frames_done++;
                        mon_active = 1'b0;
                    end else begin
                        mon_cnt++;
                    end
                end
            end
        end
    end

    // All stimulus tasks are entered and left at a falling clock edge
    task automatic push(input logic [7:0] b, output int acc, output int waited);
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = b;
        waited = 0;
        while (!bus_if.tx_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus_if.tx_ready) fail_now("push_ready_timeout");
        @(posedge clk);
        #1;
        acc = cyc;
        exp_q.push_back(b);
        @(negedge clk);
    endtask

    task automatic wait_start(output int s);
        int k = 0;
        while (start_q.size() == 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (start_q.size() == 0) begin
            fail_now("start_timeout");
            s = -1000;
        end else begin
            s = start_q.pop_front();
        end
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (frames_done < n && k < 600) begin
            @(negedge clk);
            k++;
        end
        if (frames_done < n) fail_now("frame_count_timeout");
    endtask

    task automatic wait_cyc(input int t);
        int k = 0;
        while (cyc < t && k < 1000) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, w, s, s1, s2, s3, base;
        int acc_a[6];
        int wt_a[6];

        bus_if.tx_valid = 1'b0;
        bus_if.tx_data  = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_ready", bus_if.tx_ready, 1);
        chk("reset_busy", busy, 0);
        rst_n = 1'b1;

        // Idle line after reset
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_tx", tx, 1);
            chk("idle_busy", busy, 0);
            chk("idle_ready", bus_if.tx_ready, 1);
        end
        chk("idle_no_frames", frames_done, 0);

        // Single byte 0x55
        push(8'h55, acc, w);
        bus_if.tx_valid = 1'b0;
        wait_start(s);
        chk("single_latency", s - acc, 1);
        wait_cyc(s + FRAME - 1);
        chk("single_busy_last_stop", busy, 1);
        @(negedge clk);
        chk("single_busy_fall", busy, 0);
        chk("single_tx_idle", tx, 1);
        wait_frames(1);

        // Back-to-back frames
        base = frames_done;
        push(8'hA5, acc_a[0], w);
        push(8'h3C, acc_a[1], w);
        bus_if.tx_valid = 1'b0;
        chk("b2b_accept_gap", acc_a[1] - acc_a[0], 1);
        wait_start(s1);
        wait_start(s2);
        chk("b2b_latency", s1 - acc_a[0], 1);
        chk("b2b_contiguous", s2 - s1, FRAME);
        wait_frames(base + 2);
        wait_cyc(s2 + FRAME);
        chk("b2b_busy_end", busy, 0);

        // Backpressure: 0x01 shifting, 0x02..0x05 fill the FIFO, 0x06 waits for the next pop
        base = frames_done;
        for (int i = 0; i < 6; i++) push(8'(i + 1), acc_a[i], wt_a[i]);
        bus_if.tx_valid = 1'b0;
        chk("bp_fill_no_wait", wt_a[4], 0);
        chk("bp_ready_dropped", (wt_a[5] > 0) ? 1 : 0, 1);
        chk("bp_sixth_accept", acc_a[5] - acc_a[0], 42);
        wait_frames(base + 6);
        chk("bp_queue_drained", exp_q.size(), 0);
        start_q.delete();
        repeat (4) @(negedge clk);
        chk("bp_busy_end", busy, 0);

        // Reset mid-frame during bit 3 of 0xFF with two bytes queued
        base = frames_done;
        push(8'hFF, acc, w);
        push(8'h11, acc, w);
        push(8'h22, acc, w);
        bus_if.tx_valid = 1'b0;
        wait_start(s);
        wait_cyc(s + 4 * 4 + 1);
        chk("rst_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx_async", tx, 1);
        chk("rst_busy_async", busy, 0);
        chk("rst_ready_async", bus_if.tx_ready, 1);
        exp_q.delete();
        start_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("post_rst_tx", tx, 1);
            chk("post_rst_busy", busy, 0);
        end
        chk("post_rst_no_frames", frames_done, base);

        // Push exactly on the STOP-to-START edge with one byte queued
        base = frames_done;
        push(8'h81, acc, w);
        push(8'h42, acc, w);
        bus_if.tx_valid = 1'b0;
        wait_start(s1);
        wait_cyc(s1 + FRAME - 1);
        push(8'h99, acc, w);
        bus_if.tx_valid = 1'b0;
        chk("sim_accept_edge", acc - s1, FRAME);
        chk("sim_no_wait", w, 0);
        wait_start(s2);
        wait_start(s3);
        chk("sim_second_contig", s2 - s1, FRAME);
        chk("sim_third_contig", s3 - s2, FRAME);
        wait_frames(base + 3);
        wait_cyc(s3 + FRAME);
        chk("sim_busy_end", busy, 0);
        chk("sim_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the RISC-V system's debug/host UART: the outbound counterpart of the core's `rx` line. It accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and shifts them out as 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) at a fixed clocks-per-bit rate. The transmitter sits beside the core and is driven by memory-mapped store logic or a test harness.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868 (100 MHz / 115200 baud): clock cycles per serial bit. Must be at least 2.
- `FIFO_DEPTH`, default 4: transmit FIFO entries. Must be a power of two, at least 2.

Ports:
- `clk`  in  1  the single clock; all state is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  byte to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO can accept a byte; registered, equals `!fifo_full`.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  a frame is in flight or the FIFO is non-empty.

## Operation
- Push: a byte is written into the FIFO at a rising edge where `tx_valid && tx_ready`. When `tx_valid` is high and `tx_ready` is low, nothing happens; the source must hold its data.
- FSM states are IDLE, START, DATA and STOP.
  - IDLE: `tx`=1. At an edge with the FIFO non-empty, pop the head into the 8-bit shift register, clear the baud counter and the bit index, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx`=`shift[0]`. Every `CLKS_PER_BIT` cycles, shift right and increment the bit index (3 bits). After bit index 7 completes, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Baud counter: `$clog2(CLKS_PER_BIT)` bits wide. It counts 0 to `CLKS_PER_BIT`-1 and wraps at each bit boundary. It is cleared whenever the FSM leaves IDLE.
- `tx` is driven from a flop, not decoded combinationally from the state.
- `busy` = (state != IDLE) || !fifo_empty.
- Simultaneous push and pop in one cycle (FIFO neither full nor empty): both take effect and the count is unchanged.
- Push into an empty FIFO while the FSM is idle is allowed. The pop happens at the following edge.
- Full FIFO: `tx_ready`=0. A pop that occurs in the same cycle does not raise `tx_ready` until the next cycle, because `tx_ready` is registered.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Full and empty are distinguished by an extra pointer bit.

## Timing
- Reset values: `tx`=1, `tx_ready`=1, `busy`=0, state=IDLE, FIFO empty, counters 0.
- Reset mid-frame: `tx` goes to 1 immediately (asynchronously). The frame is aborted and the FIFO contents are discarded. After `rst_n` rises, the first edge behaves as IDLE with an empty FIFO.
- Latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. `tx` falls after edge N+1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles.
- Back-to-back frames: the start bit of the next frame begins on the cycle immediately after the last stop-bit cycle.
- `busy` falls on the cycle after the final stop bit completes, provided the FIFO is empty.

## Structure
- `uart_pkg`: state enum `uart_tx_state_t` (IDLE, START, DATA, STOP), the constant `UART_DATA_BITS`=8, and the default baud constant. This package is shared with the receive side.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push, pop, full, empty, registered flags). It is instantiated once with WIDTH=8.
- The FSM, baud counter and shift register live in `uart_tx`.

## Test plan
All scenarios run with `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Idle after reset: no pushes for 50 cycles → `tx`=1, `busy`=0 and `tx_ready`=1 throughout.
- Single byte: push 0x55 → `tx` low after the push edge +1. The line then carries 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total). `busy` falls on the cycle after.
- Back-to-back frames: push 0xA5 then 0x3C on consecutive cycles → 80 contiguous cycles of frames. Data bits read LSB first as 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0. There is no high gap between the first stop bit and the second start bit.
- Backpressure: hold `tx_valid` high with 0x01 through 0x06 → 0x01 is popped into the shift register and 0x02 through 0x05 fill the FIFO, so `tx_ready` drops. 0x06 is held until `tx_ready` returns after the next pop. All six bytes are transmitted in order and none are lost.
- Reset mid-frame: assert `rst_n`=0 during bit 3 of 0xFF with 2 bytes queued → `tx`=1 immediately. After release, `busy`=0 and no further frames are sent.
- Simultaneous push and pop: push at exactly the STOP-to-START edge with 1 byte queued → the count stays at 1 and both bytes are transmitted in order.
